// File: rtl/lift_occupancy_counter_if.sv
// Bus for the lift occupancy counter: raw entry/exit sensors and clear in,
// occupancy count, status flags and reject pulses out.
interface lift_occupancy_counter_if #(
    parameter int WIDTH = 4
);
    logic             si;
    logic             so;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             full;
    logic             empty;
    logic             warn;
    logic             rejin;
    logic             rejout;

    modport master (
        output si, so, clr,
        input  count, full, empty, warn, rejin, rejout
    );

    modport slave (
        input  si, so, clr,
        output count, full, empty, warn, rejin, rejout
    );
endinterface

// File: rtl/lift_occupancy_counter.sv
// Lift occupancy counter: synchronises and debounces raw entry/exit sensors,
// then keeps a saturating head count with full/empty/warn flags and reject pulses.
module lift_occupancy_counter #(
    parameter int CAPACITY        = 9,
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WARN_LEVEL      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    lift_occupancy_counter_if.slave bus
);
    localparam int               CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [WIDTH-1:0] CAP  = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0] WARN = WIDTH'(WARN_LEVEL);
    localparam logic [CW-1:0]    LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Channel 0 is the entry sensor, channel 1 the exit sensor.
    logic [1:0]         raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         deb;
    logic [1:0]         deb_d;
    logic [1:0][CW-1:0] cnt;
    logic [1:0]         ev;
    logic               ent;
    logic               ext;

    logic [WIDTH-1:0]   count;
    logic               rejin;
    logic               rejout;

    assign raw = {bus.so, bus.si};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                // A level is accepted only after an unbroken run of differing samples.
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == LAST) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign ev  = deb & ~deb_d;
    assign ent = ev[0];
    assign ext = ev[1];

    // Clear beats events; simultaneous entry and exit cancel out with no reject.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rejin  <= 1'b0;
            rejout <= 1'b0;
        end else begin
            rejin  <= 1'b0;
            rejout <= 1'b0;
            if (bus.clr) begin
                count <= '0;
            end else if (ent && !ext) begin
                if (count >= CAP) begin
                    rejin <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (ext && !ent) begin
                if (count == '0) begin
                    rejout <= 1'b1;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    assign bus.count  = count;
    assign bus.full   = (count == CAP);
    assign bus.empty  = (count == '0);
    assign bus.warn   = (count >= WARN);
    assign bus.rejin  = rejin;
    assign bus.rejout = rejout;
endmodule

// File: tb/tb_lift_occupancy_counter.sv
// Self-checking bench for lift_occupancy_counter: press table, directed
// corner sequences and randomised sensor activity against a history-based model.
module tb_lift_occupancy_counter;
    localparam int CAPACITY        = 9;
    localparam int WIDTH           = 4;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int WARN_LEVEL      = 8;

    logic clk;
    logic rst;

    lift_occupancy_counter_if #(.WIDTH(WIDTH)) bif ();

    lift_occupancy_counter #(
        .CAPACITY       (CAPACITY),
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WARN_LEVEL     (WARN_LEVEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit si;
        bit so;
        bit clr;
        int exp_count;
        int exp_rejin;
        int exp_rejout;
    } vec_t;

    int checks = 0;
    int passed = 0;

    // Reference model: raw levels per edge since reset, accepted levels, count.
    bit rawh [2][64];
    int nedge;
    bit md1 [2];
    bit md2 [2];
    int mcount;
    bit mrejin;
    bit mrejout;

    int rin_seen;
    int rout_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        nedge   = 0;
        mcount  = 0;
        mrejin  = 1'b0;
        mrejout = 1'b0;
        for (int c = 0; c < 2; c++) begin
            md1[c] = 1'b0;
            md2[c] = 1'b0;
        end
    endtask

    // Synchronised sample seen at edge k is the raw level present two edges earlier.
    function automatic bit sampleAt(input int c, input int k);
        if (k - 2 >= 1) return rawh[c][(k - 2) % 64];
        return 1'b0;
    endfunction

    task automatic modelEdge();
        bit ent;
        bit ext;
        bit nd [2];
        if (rst) begin
            modelReset();
            return;
        end
        nedge++;
        rawh[0][nedge % 64] = bif.si;
        rawh[1][nedge % 64] = bif.so;
        ent = md1[0] & ~md2[0];
        ext = md1[1] & ~md2[1];
        for (int c = 0; c < 2; c++) begin
            bit v;
            bit run;
            v   = sampleAt(c, nedge);
            run = 1'b1;
            for (int j = 0; j < DEBOUNCE_CYCLES; j++)
                if (sampleAt(c, nedge - j) != v) run = 1'b0;
            nd[c] = (run && v != md1[c]) ? v : md1[c];
        end
        for (int c = 0; c < 2; c++) begin
            md2[c] = md1[c];
            md1[c] = nd[c];
        end
        mrejin  = 1'b0;
        mrejout = 1'b0;
        if (bif.clr) mcount = 0;
        else if (ent && !ext) begin
            if (mcount == CAPACITY) mrejin = 1'b1;
            else mcount = mcount + 1;
        end else if (ext && !ent) begin
            if (mcount == 0) mrejout = 1'b1;
            else mcount = mcount - 1;
        end
    endtask

    task automatic checkOutput();
        chk("count",  int'(bif.count),  mcount);
        chk("full",   int'(bif.full),   int'(mcount == CAPACITY));
        chk("empty",  int'(bif.empty),  int'(mcount == 0));
        chk("warn",   int'(bif.warn),   int'(mcount >= WARN_LEVEL));
        chk("rejin",  int'(bif.rejin),  int'(mrejin));
        chk("rejout", int'(bif.rejout), int'(mrejout));
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        if (bif.rejin)  rin_seen++;
        if (bif.rejout) rout_seen++;
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input bit si, input bit so, input bit clr);
        rin_seen  = 0;
        rout_seen = 0;
        if (clr) begin
            bif.clr = 1'b1;
            tick();
            bif.clr = 1'b0;
            repeat (2) tick();
        end else begin
            bif.si = si;
            bif.so = so;
            repeat (10) tick();
            bif.si = 1'b0;
            bif.so = 1'b0;
            repeat (10) tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        int   hold [2];

        vecs.push_back('{1'b0, 1'b1, 1'b0, 0, 0, 1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 0, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2, 0, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 3, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 5, 0, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 5, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 6, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 7, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 9, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 9, 1, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 9, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0, 0, 1});

        rst     = 1'b0;
        bif.si  = 1'b0;
        bif.so  = 1'b0;
        bif.clr = 1'b0;
        modelReset();

        // Asynchronous reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("reset_count", int'(bif.count), 0);
        chk("reset_empty", int'(bif.empty), 1);
        chk("reset_full",  int'(bif.full),  0);
        chk("reset_warn",  int'(bif.warn),  0);
        chk("reset_rej",   int'({bif.rejin, bif.rejout}), 0);
        repeat (2) tick();
        rst = 1'b0;

        // Entry latency: raw rise before edge 1 counts at edge DEBOUNCE_CYCLES+3.
        bif.si = 1'b1;
        rin_seen = 0;
        repeat (DEBOUNCE_CYCLES + 2) tick();
        chk("latency_before", int'(bif.count), 0);
        tick();
        chk("latency_at", int'(bif.count), 1);
        repeat (3) tick();
        chk("latency_single", int'(bif.count), 1);
        chk("latency_no_rejin", rin_seen, 0);
        bif.si = 1'b0;
        repeat (10) tick();

        // Bouncing input never stays stable long enough.
        doReset();
        for (int i = 0; i < 10; i++) begin
            bif.si = ~bif.si;
            repeat (2) tick();
        end
        bif.si = 1'b0;
        repeat (10) tick();
        chk("bounce_count", int'(bif.count), 0);

        // Press too short to qualify.
        bif.si = 1'b1;
        repeat (3) tick();
        bif.si = 1'b0;
        repeat (10) tick();
        chk("short_press", int'(bif.count), 0);

        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].si, vecs[i].so, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), int'(bif.count), vecs[i].exp_count);
            chk($sformatf("vec%0d_rejin", i), rin_seen, vecs[i].exp_rejin);
            chk($sformatf("vec%0d_rejout", i), rout_seen, vecs[i].exp_rejout);
        end

        // Async reset in the middle of a press, then release while in reset.
        doReset();
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        chk("pre_reset_count", int'(bif.count), 5);
        bif.si = 1'b1;
        repeat (4) tick();
        #3 rst = 1'b1;
        modelReset();
        #1;
        chk("midcycle_reset", int'(bif.count), 0);
        repeat (2) tick();
        bif.si = 1'b0;
        tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("after_reset_release", int'(bif.count), 0);

        // Input held through reset is a fresh press afterwards.
        bif.si = 1'b1;
        tick();
        rst = 1'b1;
        modelReset();
        repeat (2) tick();
        rst = 1'b0;
        repeat (DEBOUNCE_CYCLES + 2) tick();
        chk("held_through_reset_before", int'(bif.count), 0);
        tick();
        chk("held_through_reset_at", int'(bif.count), 1);
        bif.si = 1'b0;
        repeat (10) tick();

        // Clear coincident with an entry event wins and the event is lost.
        doReset();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        chk("pre_clr_count", int'(bif.count), 3);
        bif.si = 1'b1;
        repeat (DEBOUNCE_CYCLES + 2) tick();
        bif.clr = 1'b1;
        tick();
        bif.clr = 1'b0;
        chk("clr_with_entry", int'(bif.count), 0);
        repeat (4) tick();
        bif.si = 1'b0;
        repeat (10) tick();
        chk("clr_event_lost", int'(bif.count), 0);

        // Randomised sensor activity with occasional clears.
        doReset();
        hold[0] = 0;
        hold[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold[0] == 0) begin
                bif.si  = ~bif.si;
                hold[0] = int'($urandom_range(1, 14));
            end
            if (hold[1] == 0) begin
                bif.so  = ~bif.so;
                hold[1] = int'($urandom_range(1, 16));
            end
            hold[0]--;
            hold[1]--;
            bif.clr = ($urandom_range(0, 99) == 0);
            tick();
        end
        bif.si  = 1'b0;
        bif.so  = 1'b0;
        bif.clr = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
